// File: rtl/mm_arb_pkg.sv
// Shared types and constants for the Avalon master port arbiter.
package mm_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_GO,
    W_WAIT,
    R_GO,
    R_WAIT,
    R_ACK,
    DONE
  } state_t;

  // Returned as read data when the read master never answers
  localparam logic [31:0] BAD_READ = 32'hBAD1BAD1;

  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mm_port_arbiter_rr.sv
// Round-robin pick starting after the last grant; combinational one-hot grant.
// last_grant advances only when update is high and a requester won.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] grant
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] last_grant;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] ci;
  logic          found;
  int            cand;

  always_comb begin
    grant   = '0;
    win_idx = last_grant;
    found   = 1'b0;
    cand    = 0;
    ci      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      ci = IW'(cand);
      if (!found && req[ci]) begin
        found     = 1'b1;
        grant[ci] = 1'b1;
        win_idx   = ci;
      end
    end
  end

  // Reset value makes requester 0 the first winner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= IW'(NREQ - 1);
    end else if (update && found) begin
      last_grant <= win_idx;
    end
  end

endmodule

// File: rtl/mm_port_arbiter.sv
// Shares one Avalon read and one write master among NREQ single-word requesters.
// Latency: write 3 cycles accept->rsp, read 4; stalls on buffer_full, aborts after TIMEOUT_CYCLES.
module mm_port_arbiter
  import mm_arb_pkg::*;
#(
  parameter int ADDRESSWIDTH    = 28,
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int NREQ            = 2,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_write,
  input  logic [NREQ*ADDRESSWIDTH-1:0] req_addr,
  input  logic [NREQ*DATAWIDTH-1:0]    req_wdata,
  output logic [NREQ-1:0]              req_ready,
  output logic [NREQ-1:0]              rsp_valid,
  output logic                         rsp_err,
  output logic [DATAWIDTH-1:0]         rsp_rdata,
  output logic                         busy,

  input  logic                         write_control_done,
  input  logic                         write_user_buffer_full,
  output logic                         write_control_go,
  output logic                         write_user_write_buffer,
  output logic                         write_control_fixed_location,
  output logic [ADDRESSWIDTH-1:0]      write_control_write_base,
  output logic [ADDRESSWIDTH-1:0]      write_control_write_length,
  output logic [DATAWIDTH-1:0]         write_user_buffer_data,

  input  logic                         read_control_done,
  input  logic                         read_user_data_available,
  input  logic [DATAWIDTH-1:0]         read_user_buffer_output_data,
  output logic                         read_control_go,
  output logic                         read_user_read_buffer,
  output logic                         read_control_fixed_location,
  output logic [ADDRESSWIDTH-1:0]      read_control_read_base,
  output logic [ADDRESSWIDTH-1:0]      read_control_read_length
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state;
  logic [ADDRESSWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0]    wdata_q;
  logic [NREQ-1:0]         owner_q;
  logic                    err_q;
  logic [CW-1:0]           wait_cnt;

  logic [NREQ-1:0]         arb_req;
  logic [NREQ-1:0]         grant;
  logic                    is_idle;
  logic                    timeout_hit;
  logic [ADDRESSWIDTH-1:0] sel_addr;
  logic [DATAWIDTH-1:0]    sel_wdata;
  logic                    sel_write;

  // Requests are only visible while idle and out of reset, so req_ready
  // can never pulse mid-transaction or during reset.
  assign is_idle = (state == IDLE);
  assign arb_req = req_valid & {NREQ{is_idle && reset}};

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .update (is_idle),
    .grant  (grant)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDRESSWIDTH +: ADDRESSWIDTH];
        sel_wdata = req_wdata[i*DATAWIDTH +: DATAWIDTH];
        sel_write = req_write[i];
      end
    end
  end

  // True on the TIMEOUT_CYCLES-th consecutive cycle without the awaited input
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      owner_q   <= '0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            owner_q <= grant;
            err_q   <= 1'b0;
            state   <= sel_write ? W_GO : R_GO;
          end
        end
        W_GO: begin
          if (!write_user_buffer_full) begin
            wait_cnt <= '0;
            state    <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (write_control_done) begin
            state <= DONE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        R_GO: begin
          wait_cnt <= '0;
          state    <= R_WAIT;
        end
        R_WAIT: begin
          if (read_control_done) begin
            wait_cnt <= '0;
            state    <= R_ACK;
          end else if (timeout_hit) begin
            err_q     <= 1'b1;
            rsp_rdata <= DATAWIDTH'(BAD_READ);
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        R_ACK: begin
          if (read_user_data_available) begin
            rsp_rdata <= read_user_buffer_output_data;
            state     <= DONE;
          end else if (timeout_hit) begin
            err_q     <= 1'b1;
            rsp_rdata <= DATAWIDTH'(BAD_READ);
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = grant;
  assign busy      = !is_idle;
  assign rsp_valid = (state == DONE) ? owner_q : '0;
  assign rsp_err   = (state == DONE) && err_q;

  assign write_control_go             = (state == W_GO) && !write_user_buffer_full;
  assign write_user_write_buffer      = (state == W_GO) && !write_user_buffer_full;
  assign write_user_buffer_data       = wdata_q;
  assign write_control_fixed_location = 1'b1;
  assign write_control_write_base     = addr_q;
  assign write_control_write_length   = ADDRESSWIDTH'(BYTEENABLEWIDTH);

  assign read_control_go              = (state == R_GO);
  assign read_user_read_buffer        = (state == R_ACK) && read_user_data_available;
  assign read_control_fixed_location  = 1'b1;
  assign read_control_read_base       = addr_q;
  assign read_control_read_length     = ADDRESSWIDTH'(BYTEENABLEWIDTH);

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Directed bench for mm_port_arbiter with a hand-driven read/write master.
module tb_mm_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_write = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ready, rsp_valid;
  logic            rsp_err, busy;
  logic [DW-1:0]   rsp_rdata;
  logic            write_control_done = 1'b0, write_user_buffer_full = 1'b0;
  logic            write_control_go, write_user_write_buffer, write_control_fixed_location;
  logic [AW-1:0]   write_control_write_base, write_control_write_length;
  logic [DW-1:0]   write_user_buffer_data;
  logic            read_control_done = 1'b0, read_user_data_available = 1'b0;
  logic [DW-1:0]   read_user_buffer_output_data = '0;
  logic            read_control_go, read_user_read_buffer, read_control_fixed_location;
  logic [AW-1:0]   read_control_read_base, read_control_read_length;

  int n_cmp = 0;
  int n_err = 0;

  mm_port_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .write_control_done(write_control_done), .write_user_buffer_full(write_user_buffer_full),
    .write_control_go(write_control_go), .write_user_write_buffer(write_user_write_buffer),
    .write_control_fixed_location(write_control_fixed_location),
    .write_control_write_base(write_control_write_base), .write_control_write_length(write_control_write_length),
    .write_user_buffer_data(write_user_buffer_data),
    .read_control_done(read_control_done), .read_user_data_available(read_user_data_available),
    .read_user_buffer_output_data(read_user_buffer_output_data),
    .read_control_go(read_control_go), .read_user_read_buffer(read_user_read_buffer),
    .read_control_fixed_location(read_control_fixed_location),
    .read_control_read_base(read_control_read_base), .read_control_read_length(read_control_read_length)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    step(); step(); #1;
    if (req_ready !== 2'b00) begin $display("FAIL rst_ready got %b want 00", req_ready); n_err++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL rst_busy got %b want 0", busy); n_err++; end n_cmp++;
    if ({write_control_go, write_user_write_buffer, read_control_go, read_user_read_buffer} !== 4'b0)
      begin $display("FAIL rst_strobes got %b want 0000", {write_control_go, write_user_write_buffer, read_control_go, read_user_read_buffer}); n_err++; end n_cmp++;
    if ({rsp_valid, rsp_err} !== 3'b000) begin $display("FAIL rst_rsp got %b want 000", {rsp_valid, rsp_err}); n_err++; end n_cmp++;
    if (rsp_rdata !== 32'h0) begin $display("FAIL rst_rdata got %h want 0", rsp_rdata); n_err++; end n_cmp++;
    if ({write_control_write_base, read_control_read_base} !== 56'h0)
      begin $display("FAIL rst_bases got %h/%h want 0", write_control_write_base, read_control_read_base); n_err++; end n_cmp++;
    if ({write_control_write_length, read_control_read_length} !== {28'd4, 28'd4})
      begin $display("FAIL lengths got %0d/%0d want 4", write_control_write_length, read_control_read_length); n_err++; end n_cmp++;
    if ({write_control_fixed_location, read_control_fixed_location} !== 2'b11)
      begin $display("FAIL fixed_loc got %b want 11", {write_control_fixed_location, read_control_fixed_location}); n_err++; end n_cmp++;
    reset = 1'b1;
    req_valid = 2'b00;
  endtask

  task automatic test_single_write();
    step();
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0 +: AW] = 28'h8000090; req_wdata[0 +: DW] = 32'hAAAA0000;
    #1;
    if (req_ready !== 2'b01) begin $display("FAIL wr_ready got %b want 01", req_ready); n_err++; end n_cmp++;
    step(); req_valid = 2'b00; #1;
    if ({write_control_go, write_user_write_buffer} !== 2'b11) begin $display("FAIL wr_go got %b want 11", {write_control_go, write_user_write_buffer}); n_err++; end n_cmp++;
    if (write_user_buffer_data !== 32'hAAAA0000) begin $display("FAIL wr_data got %h want AAAA0000", write_user_buffer_data); n_err++; end n_cmp++;
    if (write_control_write_base !== 28'h8000090) begin $display("FAIL wr_base got %h want 8000090", write_control_write_base); n_err++; end n_cmp++;
    if ({busy, req_ready} !== 3'b100) begin $display("FAIL wr_busy got %b want 100", {busy, req_ready}); n_err++; end n_cmp++;
    step(); #1;
    if ({write_control_go, write_user_write_buffer} !== 2'b00) begin $display("FAIL wr_go_once got %b want 00", {write_control_go, write_user_write_buffer}); n_err++; end n_cmp++;
    step(); write_control_done = 1'b1; #1;
    if (rsp_valid !== 2'b00) begin $display("FAIL wr_early_rsp got %b want 00", rsp_valid); n_err++; end n_cmp++;
    step(); write_control_done = 1'b0; #1;
    if ({rsp_valid, rsp_err} !== 3'b010) begin $display("FAIL wr_rsp got %b want 010", {rsp_valid, rsp_err}); n_err++; end n_cmp++;
    step(); #1;
    if ({busy, rsp_valid} !== 3'b000) begin $display("FAIL wr_idle got %b want 000", {busy, rsp_valid}); n_err++; end n_cmp++;
  endtask

  task automatic test_single_read();
    step();
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 28'h8000000; #1;
    if (req_ready !== 2'b10) begin $display("FAIL rd_ready got %b want 10", req_ready); n_err++; end n_cmp++;
    step(); req_valid = 2'b00; #1;
    if (read_control_go !== 1'b1) begin $display("FAIL rd_go got %b want 1", read_control_go); n_err++; end n_cmp++;
    if (read_control_read_base !== 28'h8000000) begin $display("FAIL rd_base got %h want 8000000", read_control_read_base); n_err++; end n_cmp++;
    step(); read_control_done = 1'b1; #1;
    if ({read_control_go, read_user_read_buffer} !== 2'b00) begin $display("FAIL rd_wait got %b want 00", {read_control_go, read_user_read_buffer}); n_err++; end n_cmp++;
    step(); read_control_done = 1'b0; read_user_data_available = 1'b1; read_user_buffer_output_data = 32'h12345678; #1;
    if (read_user_read_buffer !== 1'b1) begin $display("FAIL rd_buf got %b want 1", read_user_read_buffer); n_err++; end n_cmp++;
    step(); read_user_data_available = 1'b0; read_user_buffer_output_data = 32'h0; #1;
    if ({rsp_valid, rsp_err, read_user_read_buffer} !== 4'b1000) begin $display("FAIL rd_rsp got %b want 1000", {rsp_valid, rsp_err, read_user_read_buffer}); n_err++; end n_cmp++;
    if (rsp_rdata !== 32'h12345678) begin $display("FAIL rd_rdata got %h want 12345678", rsp_rdata); n_err++; end n_cmp++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    logic [AW-1:0] exp_addr;
    step();
    req_valid = 2'b11; req_write = 2'b11;
    req_addr[0 +: AW] = 28'h0000100; req_addr[AW +: AW] = 28'h0000200;
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 28'h0000100 : 28'h0000200;
      #1;
      if (req_ready !== exp) begin $display("FAIL rr_grant%0d got %b want %b", i, req_ready, exp); n_err++; end n_cmp++;
      step(); #1;
      if ({req_ready, write_control_go} !== 3'b001) begin $display("FAIL rr_go%0d got %b want 001", i, {req_ready, write_control_go}); n_err++; end n_cmp++;
      if (write_control_write_base !== exp_addr) begin $display("FAIL rr_base%0d got %h want %h", i, write_control_write_base, exp_addr); n_err++; end n_cmp++;
      step(); write_control_done = 1'b1;
      step(); write_control_done = 1'b0; #1;
      if ({rsp_valid, req_ready} !== {exp, 2'b00}) begin $display("FAIL rr_rsp%0d got %b want %b00", i, {rsp_valid, req_ready}, exp); n_err++; end n_cmp++;
      step();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_buffer_full();
    step();
    req_valid = 2'b01; req_write = 2'b01; write_user_buffer_full = 1'b1;
    req_addr[0 +: AW] = 28'h0000440; req_wdata[0 +: DW] = 32'h5A5A0001; #1;
    if (req_ready !== 2'b01) begin $display("FAIL bf_ready got %b want 01", req_ready); n_err++; end n_cmp++;
    for (int c = 1; c <= 5; c++) begin
      step(); req_valid = 2'b00; #1;
      if ({write_control_go, write_user_write_buffer} !== 2'b00) begin $display("FAIL bf_stall%0d got %b want 00", c, {write_control_go, write_user_write_buffer}); n_err++; end n_cmp++;
    end
    step(); write_user_buffer_full = 1'b0; #1;
    if ({write_control_go, write_user_write_buffer} !== 2'b11) begin $display("FAIL bf_go got %b want 11", {write_control_go, write_user_write_buffer}); n_err++; end n_cmp++;
    if (write_user_buffer_data !== 32'h5A5A0001) begin $display("FAIL bf_data got %h want 5A5A0001", write_user_buffer_data); n_err++; end n_cmp++;
    step(); write_control_done = 1'b1;
    step(); write_control_done = 1'b0; #1;
    if (rsp_valid !== 2'b01) begin $display("FAIL bf_rsp got %b want 01", rsp_valid); n_err++; end n_cmp++;
    step();
  endtask

  task automatic test_timeout();
    step();
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 28'h0000300; #1;
    if (req_ready !== 2'b10) begin $display("FAIL to_ready got %b want 10", req_ready); n_err++; end n_cmp++;
    step(); req_valid = 2'b00;
    for (int c = 2; c <= 9; c++) step();
    #1;
    if (rsp_valid !== 2'b00) begin $display("FAIL to_early got %b want 00", rsp_valid); n_err++; end n_cmp++;
    step(); #1;
    if ({rsp_valid, rsp_err} !== 3'b101) begin $display("FAIL to_rsp got %b want 101", {rsp_valid, rsp_err}); n_err++; end n_cmp++;
    if (rsp_rdata !== 32'hBAD1BAD1) begin $display("FAIL to_rdata got %h want BAD1BAD1", rsp_rdata); n_err++; end n_cmp++;
    step();
    req_valid = 2'b01; req_write = 2'b01; #1;
    if ({req_ready, rsp_err} !== 3'b010) begin $display("FAIL to_next got %b want 010", {req_ready, rsp_err}); n_err++; end n_cmp++;
    step(); req_valid = 2'b00;
    step(); write_control_done = 1'b1;
    step(); write_control_done = 1'b0; #1;
    if ({rsp_valid, rsp_err} !== 3'b010) begin $display("FAIL to_next_rsp got %b want 010", {rsp_valid, rsp_err}); n_err++; end n_cmp++;
    step();
  endtask

  task automatic test_reset_mid();
    step();
    req_valid = 2'b01; req_write = 2'b00; req_addr[0 +: AW] = 28'h0000777; #1;
    if (req_ready !== 2'b01) begin $display("FAIL rm_ready got %b want 01", req_ready); n_err++; end n_cmp++;
    step(); req_valid = 2'b00;
    step();
    reset = 1'b0; req_valid = 2'b11; #1;
    if ({busy, rsp_valid, rsp_err, read_control_go, read_user_read_buffer, req_ready} !== 8'h00)
      begin $display("FAIL rm_outs got %b want 00000000", {busy, rsp_valid, rsp_err, read_control_go, read_user_read_buffer, req_ready}); n_err++; end n_cmp++;
    if ({rsp_rdata, read_control_read_base} !== 60'h0) begin $display("FAIL rm_regs got %h/%h want 0", rsp_rdata, read_control_read_base); n_err++; end n_cmp++;
    step(); #1;
    if (rsp_valid !== 2'b00) begin $display("FAIL rm_norsp got %b want 00", rsp_valid); n_err++; end n_cmp++;
    reset = 1'b1; #1;
    if (req_ready !== 2'b01) begin $display("FAIL rm_first got %b want 01", req_ready); n_err++; end n_cmp++;
    req_valid = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_buffer_full();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
